// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// CSR op encodings, interrupt codes, mstatus field positions and FSM states.
package trap_pkg;

  localparam int XLEN_DEFAULT = 64;

  // CSR addresses touched by the sequencer
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // CSR op encodings: writes use CSRRW, reads use CSRRS with zero write data
  localparam logic [2:0] CSR_OP_RW = 3'd0;
  localparam logic [2:0] CSR_OP_RS = 3'd1;

  // Standard machine interrupt codes
  localparam logic [5:0] IRQ_CODE_MSI = 6'd3;
  localparam logic [5:0] IRQ_CODE_MTI = 6'd7;
  localparam logic [5:0] IRQ_CODE_MEI = 6'd11;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_T_RD_MTVEC   = 4'd1,
    ST_T_RD_MSTATUS = 4'd2,
    ST_T_WR_MEPC    = 4'd3,
    ST_T_WR_MCAUSE  = 4'd4,
    ST_T_WR_MTVAL   = 4'd5,
    ST_T_WR_MSTATUS = 4'd6,
    ST_M_RD_MSTATUS = 4'd7,
    ST_M_RD_MEPC    = 4'd8,
    ST_M_WR_MSTATUS = 4'd9,
    ST_REDIRECT     = 4'd10
  } state_t;

  // True for the states that drive one CSR operation (issue + wait)
  function automatic logic is_op_state(input state_t s);
    logic r;
    case (s)
      ST_T_RD_MTVEC, ST_T_RD_MSTATUS, ST_T_WR_MEPC, ST_T_WR_MCAUSE,
      ST_T_WR_MTVAL, ST_T_WR_MSTATUS, ST_M_RD_MSTATUS, ST_M_RD_MEPC,
      ST_M_WR_MSTATUS: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

  // Successor of a CSR-op state once its operation has committed cleanly
  function automatic state_t next_op_state(input state_t s);
    state_t r;
    case (s)
      ST_T_RD_MTVEC:   r = ST_T_RD_MSTATUS;
      ST_T_RD_MSTATUS: r = ST_T_WR_MEPC;
      ST_T_WR_MEPC:    r = ST_T_WR_MCAUSE;
      ST_T_WR_MCAUSE:  r = ST_T_WR_MTVAL;
      ST_T_WR_MTVAL:   r = ST_T_WR_MSTATUS;
      ST_T_WR_MSTATUS: r = ST_REDIRECT;
      ST_M_RD_MSTATUS: r = ST_M_RD_MEPC;
      ST_M_RD_MEPC:    r = ST_M_WR_MSTATUS;
      ST_M_WR_MSTATUS: r = ST_REDIRECT;
      default:         r = ST_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Pending-interrupt priority encoder: MEI > MSI > MTI > lowest other set bit.
module irq_prio_enc
  import trap_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] irq_pending,
  output logic [5:0]      code,
  output logic            any
);

  logic [5:0] low_code_s;

  // Find the lowest set bit that is not one of the three standard interrupts
  always_comb begin
    low_code_s = 6'd0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (irq_pending[i] && (6'(i) != IRQ_CODE_MSI) && (6'(i) != IRQ_CODE_MTI)
          && (6'(i) != IRQ_CODE_MEI)) begin
        low_code_s = 6'(i);
      end else begin
        low_code_s = low_code_s;
      end
    end
  end

  // Apply the fixed priority order on top of the lowest-bit fallback
  always_comb begin
    any = |irq_pending;
    if (irq_pending[IRQ_CODE_MEI]) begin
      code = IRQ_CODE_MEI;
    end else if (irq_pending[IRQ_CODE_MSI]) begin
      code = IRQ_CODE_MSI;
    end else if (irq_pending[IRQ_CODE_MTI]) begin
      code = IRQ_CODE_MTI;
    end else begin
      code = low_code_s;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer. Walks the single-ported CSR unit
// one operation at a time (issue cycle, then wait for commit), then redirects
// fetch and flushes. All outputs are registered from the next-state values.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_valid,
  input  logic [5:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] irq_pending,
  input  logic            mstatus_mie,
  input  logic [1:0]      priv_cur,
  output logic            req_ready,
  output logic            busy_o,
  output logic            csr_issue,
  output logic [2:0]      csr_op,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic            csr_done,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_o,
  output logic [1:0]      mret_priv,
  output logic            seq_error
);

  state_t          state_r, state_s;
  logic            issue_ph_r, issue_ph_s;

  logic [5:0]      irq_code_s;
  logic            irq_any_s;
  logic            irq_take_s;
  logic            idle_s;
  logic            accept_trap_s;
  logic            accept_mret_s;
  logic            done_ok_s;
  logic            done_bad_s;

  logic            is_irq_r;
  logic [5:0]      code_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] tval_r;
  logic [1:0]      priv_r;
  logic            is_mret_r;
  logic [XLEN-1:0] mtvec_r;
  logic [XLEN-1:0] mstatus_r;
  logic [XLEN-1:0] mepc_r;
  logic            seq_error_r;

  logic [XLEN-1:0] mcause_s;
  logic [XLEN-1:0] trap_mstatus_s;
  logic [XLEN-1:0] mret_mstatus_s;
  logic [XLEN-1:0] trap_base_s;
  logic [XLEN-1:0] trap_target_s;

  logic            req_ready_s, busy_s, csr_issue_s, redirect_valid_s, flush_s;
  logic [2:0]      csr_op_s;
  logic [11:0]     csr_addr_s;
  logic [XLEN-1:0] csr_wdata_s, redirect_pc_s;
  logic [1:0]      mret_priv_s;

  logic            req_ready_r, busy_r, csr_issue_r, redirect_valid_r, flush_r;
  logic [2:0]      csr_op_r;
  logic [11:0]     csr_addr_r;
  logic [XLEN-1:0] csr_wdata_r, redirect_pc_r;
  logic [1:0]      mret_priv_r;

  irq_prio_enc #(.XLEN(XLEN)) u_irq_prio_enc (
    .irq_pending (irq_pending),
    .code        (irq_code_s),
    .any         (irq_any_s)
  );

  // Acceptance (exception > MRET > interrupt) and CSR commit qualification;
  // a commit pulse during the issue cycle is not a completion.
  assign idle_s        = (state_r == ST_IDLE);
  assign irq_take_s    = mstatus_mie & irq_any_s;
  assign accept_trap_s = idle_s & (exc_valid | (~mret_valid & irq_take_s));
  assign accept_mret_s = idle_s & ~exc_valid & mret_valid;
  assign done_ok_s     = is_op_state(state_r) & ~issue_ph_r & csr_done & ~csr_illegal;
  assign done_bad_s    = is_op_state(state_r) & ~issue_ph_r & csr_done & csr_illegal;

  // State and phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      issue_ph_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      issue_ph_r <= issue_ph_s;
    end
  end

  // Next-state logic: each op state spends one issue cycle then waits for commit
  always_comb begin
    state_s    = state_r;
    issue_ph_s = issue_ph_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_trap_s) begin
          state_s    = ST_T_RD_MTVEC;
          issue_ph_s = 1'b1;
        end else if (accept_mret_s) begin
          state_s    = ST_M_RD_MSTATUS;
          issue_ph_s = 1'b1;
        end else begin
          state_s    = ST_IDLE;
          issue_ph_s = 1'b0;
        end
      end
      ST_T_RD_MTVEC, ST_T_RD_MSTATUS, ST_T_WR_MEPC, ST_T_WR_MCAUSE,
      ST_T_WR_MTVAL, ST_T_WR_MSTATUS, ST_M_RD_MSTATUS, ST_M_RD_MEPC,
      ST_M_WR_MSTATUS: begin
        if (issue_ph_r) begin
          issue_ph_s = 1'b0;
        end else if (done_bad_s) begin
          state_s    = ST_IDLE;
          issue_ph_s = 1'b0;
        end else if (done_ok_s) begin
          state_s    = next_op_state(state_r);
          issue_ph_s = (next_op_state(state_r) != ST_REDIRECT);
        end else begin
          state_s    = state_r;
          issue_ph_s = 1'b0;
        end
      end
      ST_REDIRECT: begin
        state_s    = ST_IDLE;
        issue_ph_s = 1'b0;
      end
      default: begin
        state_s    = ST_IDLE;
        issue_ph_s = 1'b0;
      end
    endcase
  end

  // Operand capture: request details on accept, CSR read data on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_irq_r    <= 1'b0;
      code_r      <= 6'd0;
      pc_r        <= '0;
      tval_r      <= '0;
      priv_r      <= 2'b00;
      is_mret_r   <= 1'b0;
      mtvec_r     <= '0;
      mstatus_r   <= '0;
      mepc_r      <= '0;
      seq_error_r <= 1'b0;
    end else begin
      if (accept_trap_s) begin
        is_irq_r  <= ~exc_valid;
        code_r    <= exc_valid ? exc_cause : irq_code_s;
        pc_r      <= exc_pc;
        tval_r    <= exc_valid ? exc_tval : '0;
        priv_r    <= priv_cur;
        is_mret_r <= 1'b0;
      end else if (accept_mret_s) begin
        is_mret_r <= 1'b1;
      end
      if (done_ok_s) begin
        case (state_r)
          ST_T_RD_MTVEC:                    mtvec_r   <= csr_rdata;
          ST_T_RD_MSTATUS, ST_M_RD_MSTATUS: mstatus_r <= csr_rdata;
          ST_M_RD_MEPC:                     mepc_r    <= csr_rdata;
          default:                          mepc_r    <= mepc_r;
        endcase
      end
      if (done_bad_s) begin
        seq_error_r <= 1'b1;
      end
    end
  end

  // Derived write values and trap target (vectoring only for interrupts in mode 1)
  always_comb begin
    mcause_s = {is_irq_r, {(XLEN - 7){1'b0}}, code_r};

    trap_mstatus_s                                = mstatus_r;
    trap_mstatus_s[MSTATUS_MPIE]                  = mstatus_r[MSTATUS_MIE];
    trap_mstatus_s[MSTATUS_MIE]                   = 1'b0;
    trap_mstatus_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_r;

    mret_mstatus_s                                = mstatus_r;
    mret_mstatus_s[MSTATUS_MIE]                   = mstatus_r[MSTATUS_MPIE];
    mret_mstatus_s[MSTATUS_MPIE]                  = 1'b1;
    mret_mstatus_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;

    trap_base_s = {mtvec_r[XLEN-1:2], 2'b00};
    if ((mtvec_r[1:0] == 2'b01) && is_irq_r) begin
      trap_target_s = trap_base_s + {{(XLEN - 8){1'b0}}, code_r, 2'b00};
    end else begin
      trap_target_s = trap_base_s;
    end
  end

  // Output values for the upcoming cycle, decoded from the next state
  always_comb begin
    req_ready_s      = (state_s == ST_IDLE);
    busy_s           = (state_s != ST_IDLE);
    csr_issue_s      = is_op_state(state_s) & issue_ph_s;
    csr_op_s         = CSR_OP_RW;
    csr_addr_s       = 12'h000;
    csr_wdata_s      = '0;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = '0;
    flush_s          = 1'b0;
    mret_priv_s      = 2'b00;
    case (state_s)
      ST_T_RD_MTVEC: begin
        csr_op_s   = CSR_OP_RS;
        csr_addr_s = CSR_MTVEC;
      end
      ST_T_RD_MSTATUS, ST_M_RD_MSTATUS: begin
        csr_op_s   = CSR_OP_RS;
        csr_addr_s = CSR_MSTATUS;
      end
      ST_M_RD_MEPC: begin
        csr_op_s   = CSR_OP_RS;
        csr_addr_s = CSR_MEPC;
      end
      ST_T_WR_MEPC: begin
        csr_addr_s  = CSR_MEPC;
        csr_wdata_s = pc_r;
      end
      ST_T_WR_MCAUSE: begin
        csr_addr_s  = CSR_MCAUSE;
        csr_wdata_s = mcause_s;
      end
      ST_T_WR_MTVAL: begin
        csr_addr_s  = CSR_MTVAL;
        csr_wdata_s = tval_r;
      end
      ST_T_WR_MSTATUS: begin
        csr_addr_s  = CSR_MSTATUS;
        csr_wdata_s = trap_mstatus_s;
      end
      ST_M_WR_MSTATUS: begin
        csr_addr_s  = CSR_MSTATUS;
        csr_wdata_s = mret_mstatus_s;
      end
      ST_REDIRECT: begin
        redirect_valid_s = 1'b1;
        flush_s          = 1'b1;
        if (is_mret_r) begin
          redirect_pc_s = {mepc_r[XLEN-1:1], 1'b0};
          mret_priv_s   = mstatus_r[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        end else begin
          redirect_pc_s = trap_target_s;
          mret_priv_s   = 2'b00;
        end
      end
      default: begin
        csr_op_s = CSR_OP_RW;
      end
    endcase
  end

  // Output register; reset squashes any in-flight pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r      <= 1'b1;
      busy_r           <= 1'b0;
      csr_issue_r      <= 1'b0;
      csr_op_r         <= 3'd0;
      csr_addr_r       <= 12'h000;
      csr_wdata_r      <= '0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
      flush_r          <= 1'b0;
      mret_priv_r      <= 2'b00;
    end else begin
      req_ready_r      <= req_ready_s;
      busy_r           <= busy_s;
      csr_issue_r      <= csr_issue_s;
      csr_op_r         <= csr_op_s;
      csr_addr_r       <= csr_addr_s;
      csr_wdata_r      <= csr_wdata_s;
      redirect_valid_r <= redirect_valid_s;
      redirect_pc_r    <= redirect_pc_s;
      flush_r          <= flush_s;
      mret_priv_r      <= mret_priv_s;
    end
  end

  assign req_ready      = req_ready_r;
  assign busy_o         = busy_r;
  assign csr_issue      = csr_issue_r;
  assign csr_op         = csr_op_r;
  assign csr_addr       = csr_addr_r;
  assign csr_wdata      = csr_wdata_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign flush_o        = flush_r;
  assign mret_priv      = mret_priv_r;
  assign seq_error      = seq_error_r;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a table of trap/MRET vectors with
// hand-computed CSR writes and redirect targets, plus hand-written sequences
// for slow CSR commits, illegal-access abort and mid-sequence reset.
module tb_trap_sequencer;

  localparam int  XLEN       = 64;
  localparam time CLK_PERIOD = 10;

  logic            clk;
  logic            rst_n;
  logic            exc_valid;
  logic [5:0]      exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            mret_valid;
  logic [XLEN-1:0] irq_pending;
  logic            mstatus_mie;
  logic [1:0]      priv_cur;
  logic            req_ready;
  logic            busy_o;
  logic            csr_issue;
  logic [2:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_done;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_o;
  logic [1:0]      mret_priv;
  logic            seq_error;

  trap_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_valid(mret_valid),
    .irq_pending(irq_pending), .mstatus_mie(mstatus_mie), .priv_cur(priv_cur),
    .req_ready(req_ready), .busy_o(busy_o), .csr_issue(csr_issue), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_done(csr_done),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_o(flush_o), .mret_priv(mret_priv),
    .seq_error(seq_error)
  );

  initial clk = 1'b0;
  always #(CLK_PERIOD / 2) clk = ~clk;

  typedef struct {
    string       name;
    logic        exc;
    logic        mret;
    logic [5:0]  cause;
    logic [63:0] pc;
    logic [63:0] tval;
    logic [63:0] irq;
    logic        mie;
    logic [1:0]  priv;
    logic [63:0] mtvec;     // value the CSR stub returns for mtvec
    logic [63:0] mstatus;   // value the CSR stub returns for mstatus
    logic [63:0] mepc;      // value the CSR stub returns for mepc
    logic        trap;      // 1: trap sequence expected, 0: MRET sequence
    logic [63:0] mcause;
    logic [63:0] mtval;
    logic [63:0] mstw;      // expected mstatus write
    logic [63:0] redirect;
    logic [1:0]  rpriv;
  } vec_t;

  vec_t vecs[11];

  int n_pass  = 0;
  int n_total = 0;

  // Bench-side CSR stub configuration (driven by the stimulus process)
  logic [63:0] tb_mtvec, tb_mstatus, tb_mepc;
  int          csr_delay;
  logic        ill_en;
  logic [11:0] ill_addr;

  // Monitor/stub state (written only by the stub process)
  logic [11:0] log_addr[256];
  logic [2:0]  log_op[256];
  logic [63:0] log_wdata[256];
  int          log_n     = 0;
  int          dbl_issue = 0;
  int          redir_cnt = 0;
  int          flush_cnt = 0;
  logic [63:0] redir_pc_last;
  logic [1:0]  redir_priv_last;
  time         redir_t;
  int          cnt;
  logic [11:0] cur_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] stub_read(input logic [11:0] a);
    logic [63:0] r;
    case (a)
      12'h305: r = tb_mtvec;
      12'h300: r = tb_mstatus;
      12'h341: r = tb_mepc;
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  // CSR unit stub and output monitor, evaluated on the falling edge
  initial begin
    csr_done    = 1'b0;
    csr_illegal = 1'b0;
    csr_rdata   = 64'h0;
    cnt         = 0;
    cur_addr    = 12'h000;
    forever begin
      @(negedge clk);
      csr_done    = 1'b0;
      csr_illegal = 1'b0;
      csr_rdata   = 64'h0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            csr_done    = 1'b1;
            csr_rdata   = stub_read(cur_addr);
            csr_illegal = ill_en && (cur_addr == ill_addr);
          end
        end
        if (csr_issue) begin
          if (cnt > 0) dbl_issue++;
          if (log_n < 256) begin
            log_addr[log_n]  = csr_addr;
            log_op[log_n]    = csr_op;
            log_wdata[log_n] = csr_wdata;
          end
          log_n++;
          cur_addr = csr_addr;
          cnt      = csr_delay;
        end
      end
      if (redirect_valid) begin
        redir_cnt++;
        redir_pc_last   = redirect_pc;
        redir_priv_last = mret_priv;
        redir_t         = $time;
      end
      if (flush_o) flush_cnt++;
    end
  end

  task automatic drive_req(input vec_t v);
    exc_valid   = v.exc;
    mret_valid  = v.mret;
    exc_cause   = v.cause;
    exc_pc      = v.pc;
    exc_tval    = v.tval;
    irq_pending = v.irq;
    mstatus_mie = v.mie;
    priv_cur    = v.priv;
  endtask

  task automatic clear_req();
    exc_valid   = 1'b0;
    mret_valid  = 1'b0;
    irq_pending = 64'h0;
  endtask

  // Apply one vector and check the CSR op stream, write data and redirect
  task automatic run_vec(input vec_t v);
    logic [11:0] ea[6];
    logic [2:0]  eo[6];
    int          nops, l0, r0, f0, d0, bound, exp_lat;
    time         t0;
    if (v.trap) begin
      nops = 6;
      ea = '{12'h305, 12'h300, 12'h341, 12'h342, 12'h343, 12'h300};
      eo = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    end else begin
      nops = 3;
      ea = '{12'h300, 12'h341, 12'h300, 12'h000, 12'h000, 12'h000};
      eo = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    end
    exp_lat    = nops * (csr_delay + 1) + 1;
    tb_mtvec   = v.mtvec;
    tb_mstatus = v.mstatus;
    tb_mepc    = v.mepc;
    @(negedge clk);
    l0 = log_n; r0 = redir_cnt; f0 = flush_cnt; d0 = dbl_issue;
    chk({v.name, ".ready_before"}, {63'd0, req_ready}, 64'd1);
    drive_req(v);
    t0 = $time;
    @(negedge clk);
    clear_req();
    chk({v.name, ".busy_during"}, {62'd0, busy_o, req_ready}, 64'd2);
    bound = 0;
    while (!((redir_cnt > r0) && req_ready) && (bound < 400)) begin
      @(negedge clk);
      bound++;
    end
    chk({v.name, ".completes"}, {63'd0, (bound < 400)}, 64'd1);
    repeat (3) @(negedge clk);
    chk({v.name, ".n_ops"}, 64'(log_n - l0), 64'(nops));
    for (int i = 0; i < nops; i++) begin
      chk($sformatf("%s.addr%0d", v.name, i), {52'd0, log_addr[l0 + i]}, {52'd0, ea[i]});
      chk($sformatf("%s.op%0d", v.name, i), {61'd0, log_op[l0 + i]}, {61'd0, eo[i]});
    end
    chk({v.name, ".one_issue_per_op"}, 64'(dbl_issue - d0), 64'd0);
    chk({v.name, ".redirects"}, 64'(redir_cnt - r0), 64'd1);
    chk({v.name, ".flushes"}, 64'(flush_cnt - f0), 64'd1);
    chk({v.name, ".redirect_pc"}, redir_pc_last, v.redirect);
    chk({v.name, ".mret_priv"}, {62'd0, redir_priv_last}, {62'd0, v.rpriv});
    chk({v.name, ".latency"}, 64'((redir_t - t0) / CLK_PERIOD), 64'(exp_lat));
    if (v.trap) begin
      chk({v.name, ".mepc_w"}, log_wdata[l0 + 2], v.pc);
      chk({v.name, ".mcause_w"}, log_wdata[l0 + 3], v.mcause);
      chk({v.name, ".mtval_w"}, log_wdata[l0 + 4], v.mtval);
      chk({v.name, ".mstatus_w"}, log_wdata[l0 + 5], v.mstw);
    end else begin
      chk({v.name, ".mstatus_w"}, log_wdata[l0 + 2], v.mstw);
    end
  endtask

  initial begin
    int   bound, l0, r0, f0;
    vec_t v;
    rst_n     = 1'b0;
    csr_delay = 1;
    ill_en    = 1'b0;
    ill_addr  = 12'h000;
    tb_mtvec = 64'h0; tb_mstatus = 64'h0; tb_mepc = 64'h0;
    exc_cause = 6'd0; exc_pc = 64'h0; exc_tval = 64'h0; mstatus_mie = 1'b0; priv_cur = 2'b00;
    clear_req();

    //            name               exc   mret  cause  pc                      tval                    irq                     mie   priv   mtvec                   mstatus                 mepc                    trap  mcause                  mtval                   mstw                    redirect                rpriv
    vecs[0]  = '{"exc_basic",        1'b1, 1'b0, 6'd2,  64'h0000_0000_8000_0100, 64'h0000_0000_0000_dead, 64'h0,                  1'b1, 2'd3, 64'h0000_0000_8000_0000, 64'h8,                  64'h0,                  1'b1, 64'h2,                  64'h0000_0000_0000_dead, 64'h1880,               64'h0000_0000_8000_0000, 2'd0};
    vecs[1]  = '{"irq_mti_vec",      1'b0, 1'b0, 6'd9,  64'h4000,               64'h55,                 64'h80,                 1'b1, 2'd0, 64'h0000_0000_8000_0001, 64'h8,                  64'h0,                  1'b1, 64'h8000_0000_0000_0007, 64'h0,                  64'h80,                 64'h0000_0000_8000_001C, 2'd0};
    vecs[2]  = '{"irq_mei_prio",     1'b0, 1'b0, 6'd0,  64'h4100,               64'h0,                  64'h888,                1'b1, 2'd1, 64'h0000_0000_8000_0001, 64'h8,                  64'h0,                  1'b1, 64'h8000_0000_0000_000B, 64'h0,                  64'h880,                64'h0000_0000_8000_002C, 2'd0};
    vecs[3]  = '{"exc_beats_mret",   1'b1, 1'b1, 6'd5,  64'h2000,               64'h77,                 64'h0,                  1'b0, 2'd3, 64'h100,                64'h0,                  64'h0,                  1'b1, 64'h5,                  64'h77,                 64'h1800,               64'h100,                2'd0};
    vecs[4]  = '{"mret_basic",       1'b0, 1'b1, 6'd0,  64'h0,                  64'h0,                  64'h0,                  1'b0, 2'd3, 64'h0,                  64'h80,                 64'h1003,               1'b0, 64'h0,                  64'h0,                  64'h88,                 64'h1002,               2'd0};
    vecs[5]  = '{"mret_mpp3",        1'b0, 1'b1, 6'd0,  64'h0,                  64'h0,                  64'h0,                  1'b0, 2'd0, 64'h0,                  64'h1802,               64'h0000_0000_8000_0004, 1'b0, 64'h0,                  64'h0,                  64'h82,                 64'h0000_0000_8000_0004, 2'd3};
    vecs[6]  = '{"irq_low_bit",      1'b0, 1'b0, 6'd0,  64'h500,                64'h0,                  64'h0011_0000,          1'b1, 2'd3, 64'h1001,               64'h8,                  64'h0,                  1'b1, 64'h8000_0000_0000_0010, 64'h0,                  64'h1880,               64'h1040,               2'd0};
    vecs[7]  = '{"irq_mode2_direct", 1'b0, 1'b0, 6'd0,  64'h600,                64'h0,                  64'h8,                  1'b1, 2'd0, 64'h3002,               64'h0,                  64'h0,                  1'b1, 64'h8000_0000_0000_0003, 64'h0,                  64'h0,                  64'h3000,               2'd0};
    vecs[8]  = '{"irq_vec_wrap",     1'b0, 1'b0, 6'd0,  64'h700,                64'h0,                  64'h800,                1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFF1, 64'h8,                  64'h0,                  1'b1, 64'h8000_0000_0000_000B, 64'h0,                  64'h1880,               64'h1C,                 2'd0};
    vecs[9]  = '{"exc_no_vector",    1'b1, 1'b0, 6'h3F, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1234_5678_9abc_def0, 64'h80,                 1'b1, 2'd1, 64'h8001,               64'hA_0000_0002,        64'h0,                  1'b1, 64'h3F,                 64'h1234_5678_9abc_def0, 64'hA_0000_0802,        64'h8000,               2'd0};
    vecs[10] = '{"mret_beats_irq",   1'b0, 1'b1, 6'd0,  64'h0,                  64'h0,                  64'h80,                 1'b1, 2'd1, 64'h0,                  64'h1880,               64'h2468,               1'b0, 64'h0,                  64'h0,                  64'h88,                 64'h2468,               2'd3};

    // Reset state
    #(CLK_PERIOD + 2);
    chk("rst.req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst.outputs", {57'd0, busy_o, csr_issue, redirect_valid, flush_o, seq_error, mret_priv}, 64'd0);
    chk("rst.csr_bus", {49'd0, csr_op, csr_addr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of directed vectors, one-cycle CSR commit
    for (int k = 0; k < 11; k++) begin
      run_vec(vecs[k]);
    end

    // Interrupts masked by mstatus.MIE: nothing is accepted
    l0 = log_n;
    @(negedge clk);
    irq_pending = 64'h888;
    mstatus_mie = 1'b0;
    repeat (6) @(negedge clk);
    chk("masked.no_issue", 64'(log_n - l0), 64'd0);
    chk("masked.idle", {62'd0, req_ready, busy_o}, 64'd2);
    clear_req();

    // Slow CSR commit: done five cycles after each issue
    csr_delay = 5;
    run_vec(vecs[1]);
    run_vec(vecs[4]);
    csr_delay = 1;

    // Illegal CSR access on the mcause write aborts without redirect
    ill_en   = 1'b1;
    ill_addr = 12'h342;
    v = vecs[0];
    tb_mtvec = v.mtvec; tb_mstatus = v.mstatus; tb_mepc = v.mepc;
    @(negedge clk);
    l0 = log_n; r0 = redir_cnt; f0 = flush_cnt;
    drive_req(v);
    @(negedge clk);
    clear_req();
    bound = 0;
    while (!((log_n - l0 >= 4) && req_ready) && (bound < 200)) begin
      @(negedge clk);
      bound++;
    end
    chk("illegal.aborts", {63'd0, (bound < 200)}, 64'd1);
    repeat (4) @(negedge clk);
    chk("illegal.seq_error", {63'd0, seq_error}, 64'd1);
    chk("illegal.n_ops", 64'(log_n - l0), 64'd4);
    chk("illegal.no_redirect", 64'(redir_cnt - r0), 64'd0);
    chk("illegal.no_flush", 64'(flush_cnt - f0), 64'd0);
    chk("illegal.idle", {62'd0, req_ready, busy_o}, 64'd2);
    ill_en = 1'b0;
    run_vec(vecs[0]);
    chk("illegal.sticky", {63'd0, seq_error}, 64'd1);

    // Reset while waiting on the mepc write, then a clean exception
    csr_delay = 5;
    tb_mtvec = v.mtvec; tb_mstatus = v.mstatus; tb_mepc = v.mepc;
    @(negedge clk);
    l0 = log_n; r0 = redir_cnt; f0 = flush_cnt;
    drive_req(v);
    @(negedge clk);
    clear_req();
    bound = 0;
    while ((log_n - l0 < 3) && (bound < 200)) begin
      @(negedge clk);
      bound++;
    end
    chk("rstmid.reached_mepc", {63'd0, (bound < 200)}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid.idle", {60'd0, req_ready, busy_o, csr_issue, flush_o}, 64'd8);
    chk("rstmid.seq_error_cleared", {63'd0, seq_error}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    csr_delay = 1;
    repeat (8) @(negedge clk);
    chk("rstmid.no_redirect", 64'(redir_cnt - r0), 64'd0);
    chk("rstmid.no_flush", 64'(flush_cnt - f0), 64'd0);
    chk("rstmid.ops_stopped", 64'(log_n - l0), 64'd3);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
